// File: rtl/sync_fifo_pkg.sv
// Shared sizing and pointer helpers for the programmable sync FIFO.
package sync_fifo_pkg;

    function automatic int unsigned addr_w(input int unsigned depth);
        return $clog2(depth);
    endfunction

    function automatic int unsigned cnt_w(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    // Wrap explicitly so non-power-of-2 depths index only valid entries.
    function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
        return (ptr == depth - 32'd1) ? 32'd0 : ptr + 32'd1;
    endfunction

endpackage

// File: rtl/sync_fifo_prog_if.sv
// Producer/consumer handshake and status bundle for sync_fifo_prog.
interface sync_fifo_prog_if #(
    parameter int unsigned DEPTH   = 1024,
    parameter int unsigned D_WIDTH = 8
);
    import sync_fifo_pkg::*;

    localparam int unsigned CW = cnt_w(DEPTH);

    logic               wr;
    logic [D_WIDTH-1:0] w_data;
    logic               rd;
    logic [D_WIDTH-1:0] r_data;
    logic               full;
    logic               empty;
    logic               almost_full;
    logic               almost_empty;
    logic [CW-1:0]      count;
    logic               overflow;
    logic               underflow;

    modport master (
        output wr, w_data, rd,
        input  r_data, full, empty, almost_full, almost_empty, count, overflow, underflow
    );

    modport slave (
        input  wr, w_data, rd,
        output r_data, full, empty, almost_full, almost_empty, count, overflow, underflow
    );

endinterface

// File: rtl/sync_fifo_ram_dp.sv
// Simple dual-port storage: one write port, one registered read port (holds when idle).
module sync_fifo_ram_dp
    import sync_fifo_pkg::*;
#(
    parameter int unsigned DEPTH   = 1024,
    parameter int unsigned D_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      we_i,
    input  logic [addr_w(DEPTH)-1:0]  waddr_i,
    input  logic [D_WIDTH-1:0]        wdata_i,
    input  logic                      re_i,
    input  logic [addr_w(DEPTH)-1:0]  raddr_i,
    output logic [D_WIDTH-1:0]        rdata_o
);
    logic [D_WIDTH-1:0] mem_q [DEPTH];
    logic [D_WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Only the output register is reset; array contents survive reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO with occupancy count, programmable thresholds and sticky error flags.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through output; default is 1-cycle read latency.
module sync_fifo_prog
    import sync_fifo_pkg::*;
#(
    parameter int unsigned DEPTH    = 1024,
    parameter int unsigned D_WIDTH  = 8,
    parameter int unsigned AF_LEVEL = DEPTH - 4,
    parameter int unsigned AE_LEVEL = 4
) (
    input  logic            clk,
    input  logic            reset,
    sync_fifo_prog_if.slave bus
);
    localparam int unsigned AW = addr_w(DEPTH);
    localparam int unsigned CW = cnt_w(DEPTH);

    logic [AW-1:0] w_ptr_q, w_ptr_d, r_ptr_q, r_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          full_q, empty_q, af_q, ae_q, ovf_q, unf_q;
    logic          empty_d;
    logic          we_c, re_c, fetch_c;
    logic [D_WIDTH-1:0] ram_rdata;

    assign we_c = bus.wr && !full_q;
    assign re_c = bus.rd && !empty_q;

`ifdef SYNC_FIFO_FWFT_EN
    // RAM output register doubles as the head holding register; hv_q marks it valid.
    logic [CW-1:0] mem_cnt_q, mem_cnt_d;
    logic          hv_q, hv_d;

    assign fetch_c = (mem_cnt_q != '0) && (!hv_q || re_c);
    assign empty_d = !hv_d;

    always_comb begin
        mem_cnt_d = mem_cnt_q;
        hv_d      = hv_q;
        if (we_c && !fetch_c) begin
            mem_cnt_d = mem_cnt_q + CW'(1);
        end else if (fetch_c && !we_c) begin
            mem_cnt_d = mem_cnt_q - CW'(1);
        end
        if (fetch_c) begin
            hv_d = 1'b1;
        end else if (re_c) begin
            hv_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            mem_cnt_q <= '0;
            hv_q      <= 1'b0;
        end else begin
            mem_cnt_q <= mem_cnt_d;
            hv_q      <= hv_d;
        end
    end
`else
    assign fetch_c = re_c;
    assign empty_d = (count_d == '0);
`endif

    always_comb begin
        count_d = count_q;
        w_ptr_d = w_ptr_q;
        r_ptr_d = r_ptr_q;
        if (we_c && !re_c) begin
            count_d = count_q + CW'(1);
        end else if (re_c && !we_c) begin
            count_d = count_q - CW'(1);
        end
        if (we_c) begin
            w_ptr_d = AW'(ptr_inc(32'(w_ptr_q), DEPTH));
        end
        if (fetch_c) begin
            r_ptr_d = AW'(ptr_inc(32'(r_ptr_q), DEPTH));
        end
    end

    // Flags are computed from next-state count so they line up with count.
    always_ff @(posedge clk) begin
        if (!reset) begin
            w_ptr_q <= '0;
            r_ptr_q <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            af_q    <= (AF_LEVEL == 0);
            ae_q    <= 1'b1;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            w_ptr_q <= w_ptr_d;
            r_ptr_q <= r_ptr_d;
            count_q <= count_d;
            full_q  <= (32'(count_d) == DEPTH);
            empty_q <= empty_d;
            af_q    <= (32'(count_d) >= AF_LEVEL);
            ae_q    <= (32'(count_d) <= AE_LEVEL);
            ovf_q   <= ovf_q || (bus.wr && full_q);
            unf_q   <= unf_q || (bus.rd && empty_q);
        end
    end

    sync_fifo_ram_dp #(
        .DEPTH   (DEPTH),
        .D_WIDTH (D_WIDTH)
    ) u_ram (
        .clk     (clk),
        .rst_n   (reset),
        .we_i    (we_c),
        .waddr_i (w_ptr_q),
        .wdata_i (bus.w_data),
        .re_i    (fetch_c),
        .raddr_i (r_ptr_q),
        .rdata_o (ram_rdata)
    );

    assign bus.r_data       = ram_rdata;
    assign bus.full         = full_q;
    assign bus.empty        = empty_q;
    assign bus.almost_full  = af_q;
    assign bus.almost_empty = ae_q;
    assign bus.count        = count_q;
    assign bus.overflow     = ovf_q;
    assign bus.underflow    = unf_q;

endmodule

// File: tb/tb_sync_fifo_prog.sv
// Scoreboard bench for sync_fifo_prog (default read-latency build), DEPTH=5 queue reference model.
module tb_sync_fifo_prog;

    localparam int unsigned DEPTH    = 5;
    localparam int unsigned D_WIDTH  = 8;
    localparam int unsigned AF_LEVEL = 4;
    localparam int unsigned AE_LEVEL = 1;
    localparam int unsigned CW       = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [CW-1:0]      cnt;
        logic               full;
        logic               empty;
        logic               af;
        logic               ae;
        logic               ovf;
        logic               unf;
        logic [D_WIDTH-1:0] rdata;
    } exp_t;

    logic clk;
    logic reset;

    sync_fifo_prog_if #(.DEPTH(DEPTH), .D_WIDTH(D_WIDTH)) bus ();

    sync_fifo_prog #(
        .DEPTH    (DEPTH),
        .D_WIDTH  (D_WIDTH),
        .AF_LEVEL (AF_LEVEL),
        .AE_LEVEL (AE_LEVEL)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_vec = 0;
    int n_err = 0;

    exp_t               sbq [$];
    logic [D_WIDTH-1:0] mq  [$];
    logic [D_WIDTH-1:0] m_rdata = '0;
    bit                 m_ovf   = 1'b0;
    bit                 m_unf   = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference: a plain queue; read is taken from the head before the write lands.
    task automatic model_step(input bit rst, input bit w, input bit r, input logic [D_WIDTH-1:0] d);
        exp_t e;
        int   sz;
        if (rst) begin
            mq.delete();
            m_rdata = '0;
            m_ovf   = 1'b0;
            m_unf   = 1'b0;
        end else begin
            bit was_full  = (mq.size() == DEPTH);
            bit was_empty = (mq.size() == 0);
            if (w && was_full)  m_ovf = 1'b1;
            if (r && was_empty) m_unf = 1'b1;
            if (r && !was_empty) m_rdata = mq.pop_front();
            if (w && !was_full) mq.push_back(d);
        end
        sz      = mq.size();
        e.cnt   = CW'(sz);
        e.full  = (sz == DEPTH);
        e.empty = (sz == 0);
        e.af    = (sz >= AF_LEVEL);
        e.ae    = (sz <= AE_LEVEL);
        e.ovf   = m_ovf;
        e.unf   = m_unf;
        e.rdata = m_rdata;
        sbq.push_back(e);
    endtask

    task automatic cyc(input bit rst, input bit w, input bit r, input logic [D_WIDTH-1:0] d);
        reset      = !rst;
        bus.wr     = w;
        bus.rd     = r;
        bus.w_data = d;
        @(posedge clk);
        model_step(rst, w, r, d);
        @(negedge clk);
    endtask

    // Monitor: every edge with an expectation pending is compared 1 time unit later.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                chk("count",        32'(bus.count),        32'(e.cnt));
                chk("full",         32'(bus.full),         32'(e.full));
                chk("empty",        32'(bus.empty),        32'(e.empty));
                chk("almost_full",  32'(bus.almost_full),  32'(e.af));
                chk("almost_empty", 32'(bus.almost_empty), 32'(e.ae));
                chk("overflow",     32'(bus.overflow),     32'(e.ovf));
                chk("underflow",    32'(bus.underflow),    32'(e.unf));
                chk("r_data",       32'(bus.r_data),       32'(e.rdata));
            end
        end
    end

    initial begin
        int pw;
        int pr;
        pw = 50;
        pr = 50;

        // Reset with wr/rd held high
        cyc(1, 1, 1, 8'hFF);
        cyc(1, 1, 1, 8'hEE);

        // Ordered fill through thresholds, then drain
        for (int i = 0; i < 5; i++) cyc(0, 1, 0, 8'(8'h11 + i));
        for (int i = 0; i < 5; i++) cyc(0, 0, 1, 8'h00);
        cyc(0, 0, 0, 8'h00);

        // Overflow while full, then drain; overflow must stay set
        for (int i = 0; i < 5; i++) cyc(0, 1, 0, 8'(8'h21 + i));
        cyc(0, 1, 0, 8'hAA);
        cyc(0, 1, 1, 8'hAB);
        for (int i = 0; i < 6; i++) cyc(0, 0, 1, 8'h00);
        cyc(0, 0, 0, 8'h00);

        // Empty with simultaneous wr/rd
        cyc(1, 0, 0, 8'h00);
        cyc(0, 1, 1, 8'h3C);
        cyc(0, 0, 1, 8'h00);
        cyc(0, 0, 0, 8'h00);

        // Steady concurrent traffic at count=2 across pointer wrap
        cyc(1, 0, 0, 8'h00);
        cyc(0, 1, 0, 8'h40);
        cyc(0, 1, 0, 8'h41);
        for (int i = 0; i < 20; i++) cyc(0, 1, 1, 8'(8'h50 + i));
        cyc(0, 0, 1, 8'h00);
        cyc(0, 0, 1, 8'h00);

        // Randomised traffic with shifting write/read bias and rare resets
        for (int i = 0; i < 3000; i++) begin
            if (i % 200 == 0) begin
                pw = int'($urandom_range(15, 85));
                pr = int'($urandom_range(15, 85));
            end
            cyc($urandom_range(0, 299) == 0,
                $urandom_range(0, 99) < pw,
                $urandom_range(0, 99) < pr,
                8'($urandom));
        end

        cyc(0, 0, 0, 8'h00);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sync_fifo_prog.md
Name: sync_fifo_prog

Overview:
Parametrised next-generation single-clock FIFO, the successor to the basic sync FIFO.
- Adds non-power-of-2 depth, an occupancy count, programmable almost-full/almost-empty thresholds, and sticky overflow/underflow error flags.
- Sits between producer and consumer blocks in the same clock domain; drop-in for the existing FIFO with extra status outputs.

Parameters:
DEPTH, 1024, number of entries; any integer >= 2 (power of 2 not required)
D_WIDTH, 8, data width in bits
AF_LEVEL, DEPTH-4, almost_full asserts when count >= AF_LEVEL; legal 1..DEPTH
AE_LEVEL, 4, almost_empty asserts when count <= AE_LEVEL; legal 0..DEPTH-1

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous reset, active-low (0 = reset)
wr  input  1  write request
w_data  input  D_WIDTH  write data
rd  input  1  read request
r_data  output  D_WIDTH  read data
full  output  1  count == DEPTH
empty  output  1  count == 0
almost_full  output  1  count >= AF_LEVEL
almost_empty  output  1  count <= AE_LEVEL
count  output  $clog2(DEPTH+1)  current occupancy
overflow  output  1  sticky: write attempted while full
underflow  output  1  sticky: read attempted while empty

Behaviour:
Reset and qualification:
- Reset sampled on the clk edge when reset==0.
- Reset values: pointers=0, count=0, empty=1, full=0, almost_empty=1, almost_full=(AF_LEVEL==0 ? 1 : 0; 0 for legal values), overflow=0, underflow=0, r_data=0.
- Memory contents are not cleared.
- Accepted write: we = wr && !full. Accepted read: re = rd && !empty. Both are evaluated on pre-edge flags.

Pointers and count:
- w_ptr and r_ptr are $clog2(DEPTH) bits. Each increments on its accept and wraps from DEPTH-1 to 0; the explicit compare is needed for non-power-of-2 DEPTH.
- count next state: +1 if we && !re; -1 if re && !we; unchanged if both or neither.
- All flags are registered and derived from next-state count, so they are valid in the same cycle as count.

Read timing (default):
- r_data <= mem[r_ptr] on an accepted read; 1-cycle latency.
- r_data holds its value when there is no accepted read.

Boundary conditions:
- Full with wr&&rd: read accepted, write dropped, overflow set, count -> DEPTH-1.
- Empty with wr&&rd: write accepted, read dropped, underflow set, count -> 1, r_data unchanged.
- Full with wr only: write dropped, overflow set, state otherwise unchanged.
- Empty with rd only: underflow set, r_data unchanged.
- overflow and underflow are cleared only by reset.
- Reset asserted mid-stream: all data is discarded; reset values apply on the next edge regardless of wr/rd.

Optional Feature:
SYNC_FIFO_FWFT_EN: first-word-fall-through mode.
- Defined: r_data is valid while empty==0 and presents the head entry; rd pops it, and the next entry appears on the cycle after the pop.
- Implementation: one output holding register. empty deasserts one cycle after the first write into an empty FIFO. count includes the holding register.
- Undefined: default 1-cycle read latency as above.

Decomposition:
Package sync_fifo_pkg holds:
- function addr_w(depth) = $clog2(depth)
- function cnt_w(depth) = $clog2(depth+1)
- ptr_inc(ptr, depth) wrap function

Sub-module sync_fifo_ram_dp (parameters DEPTH, D_WIDTH): simple dual-port array, 1 write port and 1 synchronous read port. The top level holds pointers, count, flags and FWFT logic.

Test Plan:
1. Reset with wr=1, rd=1 asserted -> count=0, empty=1, full=0, overflow=0, underflow=0 after the edge.
2. DEPTH=5, AF_LEVEL=4, AE_LEVEL=1: write 0x11..0x15 -> almost_empty drops at count=2, almost_full at count=4, full at count=5. Then read 5 times -> r_data 0x11..0x15 in order, each 1 cycle after rd.
3. Fill DEPTH=5, pulse wr with 0xAA -> overflow=1, count stays 5. Read all 5 -> 0xAA never appears. overflow stays 1 until reset.
4. Empty FIFO, wr=rd=1 with 0x3C -> count=1, underflow=1, r_data unchanged. Next rd -> r_data=0x3C.
5. DEPTH=5, 20 cycles of concurrent wr/rd at count=2 -> count stays 2, pointers wrap, data order preserved.
6. SYNC_FIFO_FWFT_EN defined, write 0x5A into empty -> empty=0 one cycle later with r_data=0x5A before any rd; rd -> empty=1 next cycle.
